// File: rtl/elevator_scheduler.sv
// elevator_scheduler: serves up to four queued floor requests in arrival order.
// The car steps one floor every MOVE_CYCLES clocks and holds the door open for
// DOOR_CYCLES clocks per stop. A request that is already queued is absorbed. So
// is a request for the current floor while the door is open, which re-arms the
// door timer. All outputs are registered.
module elevator_scheduler #(
   parameter int unsigned MOVE_CYCLES = 2,
   parameter int unsigned DOOR_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   input  logic [2:0] req_floor,
   output logic       req_ready,
   output logic [2:0] cur_floor,
   output logic       moving_up,
   output logic       moving_down,
   output logic       door_open,
   output logic [2:0] pending,
   output logic       full,
   output logic       empty
);

   localparam int unsigned DEPTH = 4;
   localparam int unsigned PW    = 2;
   localparam int unsigned FW    = 3;
   localparam int unsigned CW    = 3;
   localparam int unsigned TMAX  = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
   localparam int unsigned TW    = $clog2(TMAX + 1);

   localparam logic [TW-1:0] MOVE_LD  = TW'(MOVE_CYCLES);
   localparam logic [TW-1:0] DOOR_LD  = TW'(DOOR_CYCLES);
   localparam logic [TW-1:0] TMR_ONE  = TW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MOVE = 2'd1,
      ST_DOOR = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [FW-1:0]   q_mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   off;
   logic [FW-1:0]   target;
   logic [FW-1:0]   target_nxt;
   logic [FW-1:0]   floor_nxt;
   logic [FW-1:0]   floor_step;
   logic [TW-1:0]   move_tmr;
   logic [TW-1:0]   move_nxt;
   logic [TW-1:0]   door_tmr;
   logic [TW-1:0]   door_nxt;
   logic [CW-1:0]   count_nxt;
   logic            accept;
   logic            hit;
   logic            door_hit;
   logic            push;
   logic            pop;
   logic            reload;

   // Compare the incoming floor against every live queue entry (head included).
   always_comb begin
      hit = 1'b0;
      off = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         off = PW'(i) - rd_ptr;
         if ((CW'(off) < pending) && (q_mem[PW'(i)] == req_floor)) begin
            hit = 1'b1;
         end
      end
   end

   // Accept decode, car next-state and the resulting queue occupancy.
   always_comb begin
      accept     = req_valid && req_ready;
      door_hit   = (state == ST_DOOR) && (req_floor == cur_floor);
      push       = accept && !hit && !door_hit;
      reload     = accept && door_hit;
      floor_step = (target > cur_floor) ? (cur_floor + FW'(1)) : (cur_floor - FW'(1));

      state_nxt  = state;
      target_nxt = target;
      floor_nxt  = cur_floor;
      move_nxt   = move_tmr;
      door_nxt   = door_tmr;
      pop        = 1'b0;

      case (state)
         ST_IDLE: begin
            if (!empty) begin
               target_nxt = q_mem[rd_ptr];
               if (q_mem[rd_ptr] == cur_floor) begin
                  pop       = 1'b1;
                  state_nxt = ST_DOOR;
                  door_nxt  = DOOR_LD;
               end else begin
                  state_nxt = ST_MOVE;
                  move_nxt  = MOVE_LD;
               end
            end
         end
         ST_MOVE: begin
            if (move_tmr <= TMR_ONE) begin
               floor_nxt = floor_step;
               move_nxt  = MOVE_LD;
               if (floor_step == target) begin
                  pop       = 1'b1;
                  state_nxt = ST_DOOR;
                  door_nxt  = DOOR_LD;
                  move_nxt  = '0;
               end
            end else begin
               move_nxt = move_tmr - TMR_ONE;
            end
         end
         ST_DOOR: begin
            if (reload) begin
               door_nxt = DOOR_LD;
            end else if (door_tmr <= TMR_ONE) begin
               state_nxt = ST_IDLE;
               door_nxt  = '0;
            end else begin
               door_nxt = door_tmr - TMR_ONE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      count_nxt = pending + CW'(push) - CW'(pop);
   end

   // Request FIFO storage and pointers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            q_mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            q_mem[wr_ptr] <= req_floor;
         end
         wr_ptr <= wr_ptr + PW'(push);
         rd_ptr <= rd_ptr + PW'(pop);
      end
   end

   // Car state, timers and registered status outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         target      <= '0;
         cur_floor   <= '0;
         move_tmr    <= '0;
         door_tmr    <= '0;
         pending     <= '0;
         full        <= 1'b0;
         empty       <= 1'b1;
         req_ready   <= 1'b1;
         moving_up   <= 1'b0;
         moving_down <= 1'b0;
         door_open   <= 1'b0;
      end else begin
         state       <= state_nxt;
         target      <= target_nxt;
         cur_floor   <= floor_nxt;
         move_tmr    <= move_nxt;
         door_tmr    <= door_nxt;
         pending     <= count_nxt;
         full        <= (count_nxt == CNT_FULL);
         empty       <= (count_nxt == '0);
         req_ready   <= (count_nxt != CNT_FULL);
         moving_up   <= (state_nxt == ST_MOVE) && (target_nxt > floor_nxt);
         moving_down <= (state_nxt == ST_MOVE) && (target_nxt < floor_nxt);
         door_open   <= (state_nxt == ST_DOOR);
      end
   end

endmodule
